// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Base pointer value after reset
    localparam int unsigned RST_PTR = 0;

    // Ceiling log2; returns 0 for v <= 1
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage : arb_pkg

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
interface rr_arbiter_if #(
    parameter int unsigned REQ_WIDTH = 16
);
    logic [REQ_WIDTH-1:0] i_req;
    logic                 i_done;
    logic [REQ_WIDTH-1:0] o_grant;
    logic                 o_grant_valid;
    logic                 o_timeout;

    // Requester side
    modport master (
        output i_req, i_done,
        input  o_grant, o_grant_valid, o_timeout
    );

    // Arbiter side
    modport slave (
        input  i_req, i_done,
        output o_grant, o_grant_valid, o_timeout
    );
endinterface : rr_arbiter_if

// File: rtl/rr_arbiter_pick.sv
// Combinational circular find-first-set starting at a base index.
module rr_pick #(
    parameter int unsigned W  = 16,
    parameter int unsigned PW = 4
) (
    input  logic [W-1:0]  req_i,
    input  logic [PW-1:0] base_i,
    output logic [W-1:0]  onehot_c,
    output logic [PW-1:0] idx_c,
    output logic          valid_c
);

    int unsigned pos;
    logic [PW-1:0] cand;

    // Scan base, base+1, ..., wrapping; first set bit wins
    always_comb begin
        onehot_c = '0;
        idx_c    = '0;
        valid_c  = 1'b0;
        pos      = 0;
        cand     = '0;
        for (int unsigned i = 0; i < W; i++) begin
            pos = 32'(base_i) + i;
            if (pos >= W) begin
                pos = pos - W;
            end
            cand = PW'(pos);
            if (!valid_c && req_i[cand]) begin
                valid_c        = 1'b1;
                idx_c          = cand;
                onehot_c[cand] = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and hold/release.
// Optional hold timeout compiled in with RR_ARB_TIMEOUT_EN.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned REQ_WIDTH = 16,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    rr_arbiter_if.slave  arb
);

    localparam int unsigned PTR_W = clog2(REQ_WIDTH);

    arb_state_t           state_q, state_d;
    logic [REQ_WIDTH-1:0] grant_q, grant_d;
    logic                 valid_q, valid_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     gidx_q, gidx_d;

    logic [PTR_W-1:0]     next_ptr_c;
    logic [PTR_W-1:0]     base_c;
    logic [REQ_WIDTH-1:0] pick_onehot_c;
    logic [PTR_W-1:0]     pick_idx_c;
    logic                 pick_valid_c;
    logic                 force_rel_c;
    logic                 release_c;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 tmo_q, tmo_d;

    assign force_rel_c = (state_q == GRANT) && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign force_rel_c = 1'b0;
`endif

    // Base for the next scan: just past the current owner when releasing
    assign next_ptr_c = (gidx_q == PTR_W'(REQ_WIDTH - 1)) ? '0 : gidx_q + PTR_W'(1);
    assign base_c     = (state_q == GRANT) ? next_ptr_c : ptr_q;
    assign release_c  = arb.i_done || !arb.i_req[gidx_q] || force_rel_c;

    rr_pick #(
        .W  (REQ_WIDTH),
        .PW (PTR_W)
    ) u_pick (
        .req_i    (arb.i_req),
        .base_i   (base_c),
        .onehot_c (pick_onehot_c),
        .idx_c    (pick_idx_c),
        .valid_c  (pick_valid_c)
    );

    // Next-state and grant selection
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
`ifdef RR_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid_c) begin
                    state_d = GRANT;
                    grant_d = pick_onehot_c;
                    valid_d = 1'b1;
                    gidx_d  = pick_idx_c;
`ifdef RR_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
                if (release_c) begin
                    ptr_d = next_ptr_c;
`ifdef RR_ARB_TIMEOUT_EN
                    tmo_d = force_rel_c;
                    cnt_d = '0;
`endif
                    if (pick_valid_c) begin
                        grant_d = pick_onehot_c;
                        valid_d = 1'b1;
                        gidx_d  = pick_idx_c;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        valid_d = 1'b0;
                    end
                end else begin
`ifdef RR_ARB_TIMEOUT_EN
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            ptr_q   <= PTR_W'(RST_PTR);
            gidx_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    // Hold counter and forced-release pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign arb.o_timeout = tmo_q;
`else
    assign arb.o_timeout = 1'b0;
`endif

    assign arb.o_grant       = grant_q;
    assign arb.o_grant_valid = valid_q;

endmodule : rr_arbiter

// File: tb/tb_rr_arbiter.sv
// Directed self-checking bench for rr_arbiter (REQ_WIDTH=16, TIMEOUT=4).
module tb_rr_arbiter;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    rr_arbiter_if #(.REQ_WIDTH(16)) arb_if ();

    rr_arbiter #(
        .REQ_WIDTH (16),
        .TIMEOUT   (4)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .arb     (arb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        arb_if.i_req  = '0;
        arb_if.i_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        arb_if.i_req  = 16'hFFFF;
        arb_if.i_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (arb_if.o_grant !== 16'h0000) begin errors++; $display("FAIL reset_grant: got %h want %h", arb_if.o_grant, 16'h0000); end
        checks++; if (arb_if.o_grant_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", arb_if.o_grant_valid); end
        checks++; if (arb_if.o_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", arb_if.o_timeout); end
        rst_n = 1'b1;
        step();
        checks++; if (arb_if.o_grant !== 16'h0001) begin errors++; $display("FAIL reset_first_grant: got %h want %h", arb_if.o_grant, 16'h0001); end
        arb_if.i_done = 1'b1;
        step();
        checks++; if (arb_if.o_grant !== 16'h0002) begin errors++; $display("FAIL reset_second_grant: got %h want %h", arb_if.o_grant, 16'h0002); end
        arb_if.i_done = 1'b0;
        // asynchronous reset mid-grant, away from any edge
        #2 rst_n = 1'b0;
        #1;
        checks++; if (arb_if.o_grant !== 16'h0000) begin errors++; $display("FAIL reset_async_clear: got %h want %h", arb_if.o_grant, 16'h0000); end
        checks++; if (arb_if.o_grant_valid !== 1'b0) begin errors++; $display("FAIL reset_async_valid: got %b want 0", arb_if.o_grant_valid); end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (arb_if.o_grant !== 16'h0001) begin errors++; $display("FAIL reset_restart_bit0: got %h want %h", arb_if.o_grant, 16'h0001); end
    endtask

    task automatic test_single();
        do_reset();
        arb_if.i_done = 1'b1;
        step();
        checks++; if (arb_if.o_grant !== 16'h0000) begin errors++; $display("FAIL idle_done_ignored: got %h want %h", arb_if.o_grant, 16'h0000); end
        arb_if.i_done = 1'b0;
        arb_if.i_req  = 16'h0001;
        #1;
        checks++; if (arb_if.o_grant_valid !== 1'b0) begin errors++; $display("FAIL single_no_comb_path: got %b want 0", arb_if.o_grant_valid); end
        step();
        checks++; if (arb_if.o_grant !== 16'h0001) begin errors++; $display("FAIL single_grant: got %h want %h", arb_if.o_grant, 16'h0001); end
        checks++; if (arb_if.o_grant_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", arb_if.o_grant_valid); end
        arb_if.i_done = 1'b1;
        step();
        checks++; if (arb_if.o_grant !== 16'h0001) begin errors++; $display("FAIL single_sole_regrant: got %h want %h", arb_if.o_grant, 16'h0001); end
        arb_if.i_req = 16'h0000;
        step();
        checks++; if (arb_if.o_grant !== 16'h0000) begin errors++; $display("FAIL single_release: got %h want %h", arb_if.o_grant, 16'h0000); end
        checks++; if (arb_if.o_grant_valid !== 1'b0) begin errors++; $display("FAIL single_release_valid: got %b want 0", arb_if.o_grant_valid); end
        arb_if.i_done = 1'b0;
    endtask

    task automatic test_wrap();
        logic [15:0] exp_seq [4];
        exp_seq = '{16'h0001, 16'h8000, 16'h0001, 16'h8000};
        do_reset();
        arb_if.i_req = 16'h8001;
        step();
        arb_if.i_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (arb_if.o_grant !== exp_seq[i]) begin errors++; $display("FAIL wrap_%0d: got %h want %h", i, arb_if.o_grant, exp_seq[i]); end
            step();
        end
        arb_if.i_done = 1'b0;
    endtask

    task automatic test_rotation();
        logic [15:0] exp_seq [5];
        exp_seq = '{16'h0010, 16'h0020, 16'h0040, 16'h0080, 16'h0010};
        do_reset();
        arb_if.i_req = 16'h00F0;
        step();
        arb_if.i_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (arb_if.o_grant !== exp_seq[i]) begin errors++; $display("FAIL rotate_%0d: got %h want %h", i, arb_if.o_grant, exp_seq[i]); end
            checks++; if (arb_if.o_grant_valid !== 1'b1) begin errors++; $display("FAIL rotate_valid_%0d: got %b want 1", i, arb_if.o_grant_valid); end
            step();
        end
        arb_if.i_done = 1'b0;
    endtask

    task automatic test_abandon();
        do_reset();
        arb_if.i_req = 16'h0104;
        step();
        checks++; if (arb_if.o_grant !== 16'h0004) begin errors++; $display("FAIL abandon_first: got %h want %h", arb_if.o_grant, 16'h0004); end
        arb_if.i_req = 16'h0F04;
        step();
        checks++; if (arb_if.o_grant !== 16'h0004) begin errors++; $display("FAIL abandon_hold: got %h want %h", arb_if.o_grant, 16'h0004); end
        arb_if.i_req = 16'h0104;
        step();
        arb_if.i_req = 16'h0100;
        step();
        checks++; if (arb_if.o_grant !== 16'h0100) begin errors++; $display("FAIL abandon_next: got %h want %h", arb_if.o_grant, 16'h0100); end
        step();
        checks++; if (arb_if.o_grant !== 16'h0100) begin errors++; $display("FAIL abandon_stable: got %h want %h", arb_if.o_grant, 16'h0100); end
        // done coincident with the drop must release only once
        do_reset();
        arb_if.i_req = 16'h0104;
        step();
        arb_if.i_req  = 16'h0100;
        arb_if.i_done = 1'b1;
        step();
        arb_if.i_done = 1'b0;
        checks++; if (arb_if.o_grant !== 16'h0100) begin errors++; $display("FAIL abandon_done_next: got %h want %h", arb_if.o_grant, 16'h0100); end
        step();
        checks++; if (arb_if.o_grant !== 16'h0100) begin errors++; $display("FAIL abandon_done_single: got %h want %h", arb_if.o_grant, 16'h0100); end
        checks++; if (arb_if.o_timeout !== 1'b0) begin errors++; $display("FAIL abandon_no_timeout: got %b want 0", arb_if.o_timeout); end
    endtask

    task automatic test_timeout();
        do_reset();
        arb_if.i_req = 16'h0003;
`ifdef RR_ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (arb_if.o_grant !== 16'h0001) begin errors++; $display("FAIL timeout_hold_%0d: got %h want %h", i, arb_if.o_grant, 16'h0001); end
            checks++; if (arb_if.o_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early_%0d: got %b want 0", i, arb_if.o_timeout); end
        end
        step();
        checks++; if (arb_if.o_grant !== 16'h0002) begin errors++; $display("FAIL timeout_next: got %h want %h", arb_if.o_grant, 16'h0002); end
        checks++; if (arb_if.o_timeout !== 1'b1) begin errors++; $display("FAIL timeout_pulse: got %b want 1", arb_if.o_timeout); end
        step();
        checks++; if (arb_if.o_timeout !== 1'b0) begin errors++; $display("FAIL timeout_pulse_width: got %b want 0", arb_if.o_timeout); end
        checks++; if (arb_if.o_grant !== 16'h0002) begin errors++; $display("FAIL timeout_next_hold: got %h want %h", arb_if.o_grant, 16'h0002); end
`else
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (arb_if.o_grant !== 16'h0001) begin errors++; $display("FAIL notimeout_hold_%0d: got %h want %h", i, arb_if.o_grant, 16'h0001); end
            checks++; if (arb_if.o_timeout !== 1'b0) begin errors++; $display("FAIL notimeout_pulse_%0d: got %b want 0", i, arb_if.o_timeout); end
        end
`endif
        arb_if.i_req = '0;
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        arb_if.i_req  = '0;
        arb_if.i_done = 1'b0;
        test_reset();
        test_single();
        test_wrap();
        test_rotation();
        test_abandon();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_rr_arbiter
